// File: rtl/bch_serial_encoder.sv
// Bit-serial systematic BCH encoder.
//
// The K_P message bits pass straight through to the output with no added latency. While they
// pass, a parity LFSR divides the message by the generator polynomial. The N_P-K_P remainder
// bits then follow, highest degree first. Both sides use a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   message bit offered
//   in_ready   message bit accepted this cycle
//   in_data    message bit, highest-degree coefficient first
//   out_valid  codeword bit presented
//   out_ready  downstream accepts the codeword bit
//   out_data   codeword bit (message bits, then parity bits)
//   out_last   current bit is the final parity bit
module bch_serial_encoder #(
    parameter int unsigned                N_P        = 15,
    parameter int unsigned                K_P        = 7,
    parameter logic [N_P-K_P:0]           GEN_POLY_P = 9'h1D1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_data,
    output logic out_valid,
    input  logic out_ready,
    output logic out_data,
    output logic out_last
);

    localparam int unsigned P    = N_P - K_P;
    localparam int unsigned CntW = (N_P > 1) ? $clog2(N_P) : 1;

    // Reject parameter sets that cannot describe a valid code.
    if (K_P < 1 || N_P <= K_P) begin : g_bad_len
        $fatal(1, "bch_serial_encoder: need K_P >= 1 and N_P > K_P");
    end else if (GEN_POLY_P[P] != 1'b1 || GEN_POLY_P[0] != 1'b1) begin : g_bad_poly
        $fatal(1, "bch_serial_encoder: generator must have x^P and x^0 terms");
    end

    typedef enum logic {StMsg, StPar} state_e;

    state_e          state_q, state_d;
    logic [P-1:0]    r_q, r_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            fb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StMsg;
            r_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        cnt_d     = cnt_q;
        fb        = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 1'b0;
        out_last  = 1'b0;

        unique case (state_q)
            StMsg: begin
                // The message path is combinational: the sink sees the source directly.
                out_valid = in_valid;
                out_data  = in_data;
                in_ready  = out_ready;
                if (in_valid && out_ready) begin
                    fb  = in_data ^ r_q[P-1];
                    r_d = (r_q << 1) ^ (fb ? GEN_POLY_P[P-1:0] : '0);
                    if (cnt_q == CntW'(K_P - 1)) begin
                        cnt_d   = '0;
                        state_d = StPar;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StPar: begin
                out_valid = 1'b1;
                out_data  = r_q[P-1];
                out_last  = (cnt_q == CntW'(P - 1));
                if (out_ready) begin
                    if (out_last) begin
                        state_d = StMsg;
                        r_d     = '0;
                        cnt_d   = '0;
                    end else begin
                        r_d   = r_q << 1;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StMsg;
            end
        endcase
    end

endmodule

// File: tb/tb_bch_serial_encoder.sv
module tb_bch_serial_encoder;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_ready, in_data, out_valid, out_ready, out_data, out_last;
    logic in_valid7, in_ready7, in_data7, out_valid7, out_ready7, out_data7, out_last7;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bch_serial_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    bch_serial_encoder #(
        .N_P        (7),
        .K_P        (4),
        .GEN_POLY_P (4'hB)
    ) dut7 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid7),
        .in_ready  (in_ready7),
        .in_data   (in_data7),
        .out_valid (out_valid7),
        .out_ready (out_ready7),
        .out_data  (out_data7),
        .out_last  (out_last7)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: codeword = message followed by remainder of m(x)*x^8 mod g(x), by long division.
    function automatic logic [14:0] model_cw(input logic [6:0] msg);
        logic [14:0] rem;
        logic [14:0] g;
        g   = 15'h01D1;
        rem = {msg, 8'h00};
        for (int i = 14; i >= 8; i--) begin
            if (rem[i]) rem = rem ^ (g << (i - 8));
        end
        return {msg, rem[7:0]};
    endfunction

    // Push one codeword through the default encoder. Stall percentage applies to out_ready.
    // Entered and left at posedge+1, so consecutive calls are back to back.
    task automatic send(input logic [6:0] msg, input logic [14:0] exp_cw, input int pct,
                        output int cycles);
        int   j      = 0;
        int   budget = 0;
        logic held   = 1'b0;
        logic held_d = 1'b0;
        cycles = 0;
        while (j < 15 && budget < 400) begin
            in_valid  = 1'b1;
            // During parity, offer junk that must be ignored.
            in_data   = (j < 7) ? msg[6-j] : 1'($urandom);
            out_ready = ($urandom_range(99) >= 32'(pct));
            #4;
            if (held) check("stall_data_stable", {31'd0, out_data}, {31'd0, held_d});
            check("out_valid", {31'd0, out_valid}, 32'd1);
            check("in_ready", {31'd0, in_ready}, (j < 7) ? {31'd0, out_ready} : 32'd0);
            if (out_valid && out_ready) begin
                check("out_data", {31'd0, out_data}, {31'd0, exp_cw[14-j]});
                check("out_last", {31'd0, out_last}, (j == 14) ? 32'd1 : 32'd0);
                j++;
                held = 1'b0;
            end else begin
                held   = 1'b1;
                held_d = out_data;
            end
            @(posedge clk);
            #1;
            cycles++;
            budget++;
        end
        if (j < 15) check("codeword_timeout", 32'(j), 32'd15);
    endtask

    task automatic send7(input logic [3:0] msg, input logic [6:0] exp_cw);
        int j      = 0;
        int budget = 0;
        while (j < 7 && budget < 50) begin
            in_valid7  = 1'b1;
            in_data7   = (j < 4) ? msg[3-j] : 1'b0;
            out_ready7 = 1'b1;
            #4;
            if (out_valid7) begin
                check("n7_data", {31'd0, out_data7}, {31'd0, exp_cw[6-j]});
                check("n7_last", {31'd0, out_last7}, (j == 6) ? 32'd1 : 32'd0);
                j++;
            end
            @(posedge clk);
            #1;
            budget++;
        end
        if (j < 7) check("n7_timeout", 32'(j), 32'd7);
        in_valid7 = 1'b0;
    endtask

    typedef struct {
        logic [6:0] msg;
        logic [7:0] parity;
    } vec_t;

    vec_t vecs[6];
    int   cyc;
    logic [6:0] rmsg;

    initial begin
        vecs[0] = '{7'h00, 8'h00};
        vecs[1] = '{7'h01, 8'hD1};
        vecs[2] = '{7'h02, 8'h73};
        vecs[3] = '{7'h03, 8'hA2};
        vecs[4] = '{7'h40, 8'hE8};
        vecs[5] = '{7'h7F, 8'hFF};

        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_data    = 1'b1;
        out_ready  = 1'b1;
        in_valid7  = 1'b0;
        in_data7   = 1'b0;
        out_ready7 = 1'b1;

        // Outputs in reset follow the pass-through path; clocking in reset must not move state.
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd1);
        check("rst_out_data", {31'd0, out_data}, 32'd1);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        out_ready = 1'b0;
        #1;
        check("rst_in_ready_lo", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            send(vecs[i].msg, {vecs[i].msg, vecs[i].parity}, 0, cyc);
            check("table_cycles", 32'(cyc), 32'd15);
        end

        // Full throughput over three back-to-back codewords.
        for (int i = 0; i < 3; i++) begin
            rmsg = 7'($urandom);
            send(rmsg, model_cw(rmsg), 0, cyc);
            check("throughput_cycles", 32'(cyc), 32'd15);
        end

        // Stalls in both phases.
        for (int i = 0; i < 3; i++) send(7'h01, {7'h01, 8'hD1}, 50, cyc);
        for (int i = 0; i < 20; i++) begin
            rmsg = 7'($urandom);
            send(rmsg, model_cw(rmsg), 50, cyc);
        end

        // Abort after 3 message bits.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 1'($urandom);
            @(posedge clk);
            #1;
        end
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #2;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_last", {31'd0, out_last}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(7'h01, {7'h01, 8'hD1}, 0, cyc);

        // Short (7,4) code.
        in_valid = 1'b0;
        send7(4'b1000, 7'b1000101);
        send7(4'b0001, 7'b0001011);
        send7(4'b1011, 7'b1011000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bch_serial_encoder.md
BCH_SERIAL_ENCODER -- requirements
Module: bch_serial_encoder

Interface
REQ-001 The block SHALL have parameter N_P, default 15, meaning the codeword length n in bits.
REQ-002 The block SHALL have parameter K_P, default 7, meaning the message length k in bits.
REQ-003 The block SHALL have parameter GEN_POLY_P, width N_P-K_P+1, default 9'h1D1 (x^8+x^7+x^6+x^4+1, BCH(15,7) t=2), meaning the generator polynomial with MSB = x^(N_P-K_P).
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, meaning the asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit, meaning a message bit is offered.
REQ-007 The block SHALL have port in_ready, output, 1 bit, meaning the message bit is accepted this cycle.
REQ-008 The block SHALL have port in_data, input, 1 bit, meaning the message bit, highest-degree coefficient first.
REQ-009 The block SHALL have port out_valid, output, 1 bit, meaning a codeword bit is presented.
REQ-010 The block SHALL have port out_ready, input, 1 bit, meaning the downstream sink accepts the codeword bit.
REQ-011 The block SHALL have port out_data, output, 1 bit, meaning the codeword bit, systematic: K_P message bits, then N_P-K_P parity bits.
REQ-012 The block SHALL have port out_last, output, 1 bit, meaning the current codeword bit is the final parity bit.

Function
REQ-013 The block SHALL contain a parity LFSR r of P=N_P-K_P bits, a bit counter of ceil(log2(N_P)) bits, and a two-state FSM: ST_MSG, ST_PAR.
REQ-014 In ST_MSG, the block SHALL drive out_valid=in_valid, out_data=in_data and in_ready=out_ready, with zero cycles of latency from in_data to out_data.
REQ-015 A message transfer SHALL occur when in_valid and out_ready are both 1; on a transfer, fb=in_data XOR r[P-1] and r <= (r<<1) XOR (fb ? GEN_POLY_P[P-1:0] : 0).
REQ-016 The bit counter SHALL increment on each transfer; on the K_P-th message transfer, the counter SHALL clear and the FSM SHALL move to ST_PAR.
REQ-017 In ST_PAR, the block SHALL drive in_ready=0, out_valid=1 and out_data=r[P-1].
REQ-018 On each accepted parity bit (out_ready=1), r SHALL shift left by one with zero fill and the counter SHALL increment.
REQ-019 out_last SHALL be 1 only in ST_PAR while the counter equals P-1; on acceptance of that bit, the FSM SHALL return to ST_MSG with r=0 and counter=0.
REQ-020 When out_ready=0, every state, counter and r value SHALL hold, and out_data/out_valid SHALL remain stable (the AXI-stream-style rule that there is no retraction once valid).
REQ-021 Back-to-back codewords SHALL incur no idle cycle: the first message bit of the next codeword is accepted in the cycle after the last parity bit is accepted.
REQ-022 Message bits offered in ST_PAR SHALL be ignored (in_ready=0) and left pending for ST_MSG.
REQ-023 Elaboration SHALL fail ($fatal) if K_P<1, N_P<=K_P, or GEN_POLY_P[P] != 1 or GEN_POLY_P[0] != 1.

Reset
REQ-024 When rst_n=0, the block SHALL asynchronously force FSM=ST_MSG, r=0 and counter=0.
REQ-025 During reset, outputs SHALL follow REQ-014 with r=0, so that in_ready=out_ready, out_valid=in_valid and out_last=0; no transfer SHALL update state while rst_n=0.
REQ-026 Reset asserted mid-codeword SHALL discard the partial codeword; after release, the next accepted bit SHALL be treated as message bit 0.

Verification
REQ-027 Default parameters, message 0000000 with out_ready=1 SHALL produce codeword 15 zeros, with out_last high only on bit 14.
REQ-028 Default parameters, message 0000001 SHALL produce parity bits, in order, 1,1,0,1,0,0,0,1 (0xD1).
REQ-029 N_P=7, K_P=4, GEN_POLY_P=4'hB with message 1000 SHALL produce codeword 1000101; message 0001 SHALL produce codeword 0001011.
REQ-030 Random out_ready stalls (50%) during both message and parity phases SHALL produce the same codewords as REQ-028, with out_data stable across every stall.
REQ-031 Continuous in_valid=1 over 3 codewords SHALL achieve full throughput of 15 output bits per 15 cycles, with in_ready=0 exactly during the 8 parity cycles.
REQ-032 rst_n pulsed low after 3 message bits, then message 0000001 SHALL produce parity 0xD1, with no residue from the aborted codeword.
